// File: rtl/ysyx_22041211_lsu_axi.sv
// ysyx_22041211_lsu_axi: load/store unit between EXU and WBU, driving a
// valid/ready request/response memory bus with byte-lane strobes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses trap
// with cause 4/6 instead of being truncated to an aligned address).
// Encodings: load_type 1=LB 2=LH 3=LW 4=LBU 5=LHU (6/7 treated as LW),
//            store_type 1=SB 2=SH 3=SW.
module ysyx_22041211_lsu_axi #(
  parameter int DATA_LEN    = 32,
  parameter int ADDR_LEN    = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid_i,
  output logic                  lsu_ready_o,
  input  logic                  wd_i,
  input  logic [4:0]            wreg_i,
  input  logic [ADDR_LEN-1:0]   alu_result_i,
  input  logic [DATA_LEN-1:0]   mem_wdata_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [DATA_LEN-1:0]   csr_wdata_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_wen_o,
  output logic [ADDR_LEN-1:0]   mem_req_addr_o,
  output logic [DATA_LEN-1:0]   mem_req_wdata_o,
  output logic [DATA_LEN/8-1:0] mem_req_wstrb_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_LEN-1:0]   mem_rsp_rdata_i,
  input  logic                  mem_rsp_err_i,
  output logic                  lsu_valid_o,
  input  logic                  wbu_ready_i,
  output logic                  wd_o,
  output logic [4:0]            wreg_o,
  output logic [DATA_LEN-1:0]   wdata_o,
  output logic [DATA_LEN-1:0]   csr_wdata_o,
  output logic                  exc_o,
  output logic [3:0]            exc_cause_o,
  output logic [ADDR_LEN-1:0]   exc_tval_o
);

  localparam int STRB_W = DATA_LEN / 8;
  localparam int LANE_W = $clog2(STRB_W);

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;
  localparam logic [1:0] ST_SB  = 2'd1;
  localparam logic [1:0] ST_SH  = 2'd2;

  localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_DONE} state_t;

  state_t              state_reg;
  logic                ready_reg;
  logic                req_valid_reg;
  logic                req_wen_reg;
  logic [ADDR_LEN-1:0] req_addr_reg;
  logic [DATA_LEN-1:0] req_wdata_reg;
  logic [STRB_W-1:0]   req_wstrb_reg;
  logic                valid_reg;
  logic                wd_reg;
  logic [4:0]          wreg_reg;
  logic [DATA_LEN-1:0] wdata_reg;
  logic [DATA_LEN-1:0] csr_reg;
  logic                exc_reg;
  logic [3:0]          cause_reg;
  logic [ADDR_LEN-1:0] tval_reg;
  logic                is_ld_reg;
  logic [2:0]          ld_type_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [31:0]         tmo_cnt_reg;

  // Access decode of the instruction currently offered by the EXU
  logic                acc_is_ld;
  logic                acc_is_mem;
  logic [1:0]          acc_size;     // 0 byte, 1 halfword, 2 word
  logic [LANE_W-1:0]   raw_lane;
  logic [LANE_W-1:0]   align_mask;
  logic [LANE_W-1:0]   acc_lane;
  logic [STRB_W-1:0]   acc_strb;
  logic [DATA_LEN-1:0] acc_wdata;
  logic                acc_trap;

  // Decode size, aligned lane, strobes and shifted store data
  always_comb begin
    acc_is_ld  = |load_type_i;
    acc_is_mem = acc_is_ld | (|store_type_i);
    acc_size   = 2'd2;
    if (acc_is_ld) begin
      if (load_type_i == LD_LB || load_type_i == LD_LBU)      acc_size = 2'd0;
      else if (load_type_i == LD_LH || load_type_i == LD_LHU) acc_size = 2'd1;
    end else begin
      if (store_type_i == ST_SB)      acc_size = 2'd0;
      else if (store_type_i == ST_SH) acc_size = 2'd1;
    end
    raw_lane = alu_result_i[LANE_W-1:0];
    unique case (acc_size)
      2'd0:    align_mask = ~LANE_W'(0);
      2'd1:    align_mask = ~LANE_W'(1);
      default: align_mask = ~LANE_W'(3);
    endcase
    // Offsets below the access size are dropped so the access stays in-word
    acc_lane = raw_lane & align_mask;
    unique case (acc_size)
      2'd0:    acc_strb = STRB_W'(1)  << acc_lane;
      2'd1:    acc_strb = STRB_W'(3)  << acc_lane;
      default: acc_strb = STRB_W'(15) << acc_lane;
    endcase
    acc_wdata = mem_wdata_i << {acc_lane, 3'b000};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign acc_trap = acc_is_mem & (|(raw_lane & ~align_mask));
`else
  assign acc_trap = 1'b0;
`endif

  logic [DATA_LEN-1:0] ld_shift;
  logic [DATA_LEN-1:0] ld_ext;

  // Align the returned bus word to bit 0 and extend it per load type
  always_comb begin
    ld_shift = mem_rsp_rdata_i >> {lane_reg, 3'b000};
    case (ld_type_reg)
      LD_LB:   ld_ext = DATA_LEN'($signed(ld_shift[7:0]));
      LD_LH:   ld_ext = DATA_LEN'($signed(ld_shift[15:0]));
      LD_LBU:  ld_ext = DATA_LEN'(ld_shift[7:0]);
      LD_LHU:  ld_ext = DATA_LEN'(ld_shift[15:0]);
      default: ld_ext = DATA_LEN'($signed(ld_shift[31:0]));
    endcase
  end

  // Main FSM: accept, issue request, await response, hold result for WBU
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      ready_reg     <= 1'b1;
      req_valid_reg <= 1'b0;
      req_wen_reg   <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_wstrb_reg <= '0;
      valid_reg     <= 1'b0;
      wd_reg        <= 1'b0;
      wreg_reg      <= '0;
      wdata_reg     <= '0;
      csr_reg       <= '0;
      exc_reg       <= 1'b0;
      cause_reg     <= '0;
      tval_reg      <= '0;
      is_ld_reg     <= 1'b0;
      ld_type_reg   <= '0;
      lane_reg      <= '0;
      tmo_cnt_reg   <= '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (exu_valid_i) begin
            ready_reg   <= 1'b0;
            wd_reg      <= wd_i;
            wreg_reg    <= wreg_i;
            csr_reg     <= csr_wdata_i;
            wdata_reg   <= DATA_LEN'(alu_result_i);
            tval_reg    <= alu_result_i;
            is_ld_reg   <= acc_is_ld;
            ld_type_reg <= load_type_i;
            lane_reg    <= acc_lane;
            exc_reg     <= 1'b0;
            cause_reg   <= '0;
            if (acc_trap) begin
              state_reg <= S_DONE;
              valid_reg <= 1'b1;
              exc_reg   <= 1'b1;
              cause_reg <= acc_is_ld ? CAUSE_LD_MIS : CAUSE_ST_MIS;
              wd_reg    <= 1'b0;
            end else if (acc_is_mem) begin
              state_reg     <= S_REQ;
              req_valid_reg <= 1'b1;
              req_wen_reg   <= ~acc_is_ld;
              req_addr_reg  <= {alu_result_i[ADDR_LEN-1:LANE_W], LANE_W'(0)};
              req_wdata_reg <= acc_is_ld ? '0 : acc_wdata;
              req_wstrb_reg <= acc_is_ld ? '0 : acc_strb;
            end else begin
              state_reg <= S_DONE;
              valid_reg <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready_i) begin
            req_valid_reg <= 1'b0;
            tmo_cnt_reg   <= '0;
            state_reg     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (mem_rsp_valid_i) begin
            state_reg <= S_DONE;
            valid_reg <= 1'b1;
            if (mem_rsp_err_i) begin
              exc_reg   <= 1'b1;
              cause_reg <= is_ld_reg ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
              wd_reg    <= 1'b0;
            end else if (is_ld_reg) begin
              wdata_reg <= ld_ext;
            end
          end else if (TIMEOUT_CYC != 0 && tmo_cnt_reg == 32'(TIMEOUT_CYC)) begin
            state_reg <= S_DONE;
            valid_reg <= 1'b1;
            exc_reg   <= 1'b1;
            cause_reg <= is_ld_reg ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
            wd_reg    <= 1'b0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          end
        end
        S_DONE: begin
          if (wbu_ready_i) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign lsu_ready_o     = ready_reg;
  assign mem_req_valid_o = req_valid_reg;
  assign mem_req_wen_o   = req_wen_reg;
  assign mem_req_addr_o  = req_addr_reg;
  assign mem_req_wdata_o = req_wdata_reg;
  assign mem_req_wstrb_o = req_wstrb_reg;
  assign lsu_valid_o     = valid_reg;
  assign wd_o            = wd_reg;
  assign wreg_o          = wreg_reg;
  assign wdata_o         = wdata_reg;
  assign csr_wdata_o     = csr_reg;
  assign exc_o           = exc_reg;
  assign exc_cause_o     = cause_reg;
  assign exc_tval_o      = tval_reg;

endmodule

// File: tb/tb_ysyx_22041211_lsu_axi.sv
// Testbench for ysyx_22041211_lsu_axi (DATA_LEN=32, TIMEOUT_CYC=4).
// Honours LSU_MISALIGN_TRAP_EN when the bench is compiled with it.
module tb_ysyx_22041211_lsu_axi;

  localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exu_valid_i = 0, lsu_ready_o;
  logic        wd_i = 0;
  logic [4:0]  wreg_i = 0;
  logic [31:0] alu_result_i = 0, mem_wdata_i = 0, csr_wdata_i = 0;
  logic [2:0]  load_type_i = 0;
  logic [1:0]  store_type_i = 0;
  logic        mem_req_valid_o, mem_req_ready_i = 0, mem_req_wen_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic [3:0]  mem_req_wstrb_o;
  logic        mem_rsp_valid_i = 0, mem_rsp_err_i = 0;
  logic [31:0] mem_rsp_rdata_i = 0;
  logic        lsu_valid_o, wbu_ready_i = 0, wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o, csr_wdata_o, exc_tval_o;
  logic        exc_o;
  logic [3:0]  exc_cause_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_22041211_lsu_axi #(.DATA_LEN(32), .ADDR_LEN(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .exu_valid_i(exu_valid_i), .lsu_ready_o(lsu_ready_o),
    .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i),
    .mem_wdata_i(mem_wdata_i), .load_type_i(load_type_i), .store_type_i(store_type_i),
    .csr_wdata_i(csr_wdata_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_wen_o(mem_req_wen_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .mem_rsp_err_i(mem_rsp_err_i),
    .lsu_valid_o(lsu_valid_o), .wbu_ready_i(wbu_ready_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .csr_wdata_o(csr_wdata_o),
    .exc_o(exc_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o)
  );

  typedef struct {
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] alu, wdata, csr, rdata;
    logic [2:0]  ld;
    logic [1:0]  st;
    int          req_delay, rsp_delay, wbu_delay;
    bit          err, no_rsp, stray;
  } txn_t;

  typedef struct {
    bit          timed_out, req_seen, req_unstable, req_in_done, out_unstable;
    int          lat, valid_cycles;
    logic        wen;
    logic [31:0] addr, bwdata;
    logic [3:0]  strb;
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] res, csr, tval;
    logic        exc;
    logic [3:0]  cause;
    logic        valid_after, ready_after, ready_before;
  } obs_t;

  typedef struct {
    bit          mem, wen, exc, wd;
    logic [31:0] addr, bwdata, res;
    logic [3:0]  strb, cause;
  } exp_t;

  // Reference model: what one instruction should do, from the access rules
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int size, lane, bits;
    bit is_ld, is_st, mis, trap, sgn;
    longint unsigned v;
    is_ld = (t.ld != 0);
    is_st = !is_ld && (t.st != 0);
    if (is_ld) size = (t.ld == 1 || t.ld == 4) ? 1 : (t.ld == 2 || t.ld == 5) ? 2 : 4;
    else       size = (t.st == 1) ? 1 : (t.st == 2) ? 2 : 4;
    lane = int'(t.alu % 4);
    mis  = (is_ld || is_st) && (lane % size != 0);
    trap = TRAP && mis;
    lane = lane - (lane % size);
    e.mem    = (is_ld || is_st) && !trap;
    e.wen    = is_st;
    e.addr   = t.alu - (t.alu % 4);
    e.strb   = is_st ? 4'(((1 << size) - 1) << lane) : 4'd0;
    e.bwdata = is_st ? (t.wdata << (8 * lane)) : 32'd0;
    e.exc    = trap || (e.mem && (t.err || t.no_rsp));
    e.cause  = trap ? (is_ld ? 4'd4 : 4'd6) : (is_ld ? 4'd5 : 4'd7);
    e.wd     = e.exc ? 1'b0 : t.wd;
    e.res    = t.alu;
    if (is_ld) begin
      bits = 8 * size;
      sgn  = (t.ld == 1 || t.ld == 2);
      v = longint'(t.rdata >> (8 * lane)) % (longint'(1) << bits);
      if (sgn && v >= (longint'(1) << (bits - 1)))
        v = v + (longint'(1) << 32) - (longint'(1) << bits);
      e.res = v[31:0];
    end
    return e;
  endfunction

  function automatic bit outs_differ(input obs_t o);
    return (wd_o !== o.wd) || (wreg_o !== o.wreg) || (wdata_o !== o.res) ||
           (csr_wdata_o !== o.csr) || (exc_o !== o.exc) || (exc_cause_o !== o.cause) ||
           (exc_tval_o !== o.tval);
  endfunction

  // Drive one instruction through EXU, bus and WBU handshakes, recording what happened
  task automatic run_txn(input txn_t t, output obs_t o);
    int  rq, rs;
    bit  done;
    o  = '{default: 0};
    rq = t.req_delay;
    rs = t.rsp_delay;
    @(negedge clk);
    o.ready_before = lsu_ready_o;
    exu_valid_i = 1; wd_i = t.wd; wreg_i = t.wreg; alu_result_i = t.alu;
    mem_wdata_i = t.wdata; load_type_i = t.ld; store_type_i = t.st; csr_wdata_i = t.csr;
    @(posedge clk); #1;
    exu_valid_i = 0; wd_i = 1'($urandom); wreg_i = 5'($urandom); alu_result_i = $urandom;
    mem_wdata_i = $urandom; load_type_i = 3'($urandom); store_type_i = 2'($urandom);
    csr_wdata_i = $urandom;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_err_i = 0;
      if (lsu_valid_o) begin
        done = 1; o.lat = c;
      end else if (mem_req_valid_o) begin
        if (!o.req_seen) begin
          o.req_seen = 1; o.wen = mem_req_wen_o; o.addr = mem_req_addr_o;
          o.bwdata = mem_req_wdata_o; o.strb = mem_req_wstrb_o;
        end else if (mem_req_wen_o !== o.wen || mem_req_addr_o !== o.addr ||
                     mem_req_wdata_o !== o.bwdata || mem_req_wstrb_o !== o.strb) begin
          o.req_unstable = 1;
        end
        if (rq == 0) mem_req_ready_i = 1; else rq--;
        if (t.stray) begin mem_rsp_valid_i = 1; mem_rsp_rdata_i = ~t.rdata; end
      end else if (o.req_seen && !t.no_rsp) begin
        if (rs == 0) begin
          mem_rsp_valid_i = 1; mem_rsp_rdata_i = t.rdata; mem_rsp_err_i = t.err;
        end else rs--;
      end
    end
    mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_err_i = 0;
    if (!done) begin o.timed_out = 1; return; end
    o.wd = wd_o; o.wreg = wreg_o; o.res = wdata_o; o.csr = csr_wdata_o;
    o.exc = exc_o; o.cause = exc_cause_o; o.tval = exc_tval_o;
    for (int k = 0; k < t.wbu_delay; k++) begin
      if (lsu_valid_o) o.valid_cycles++;
      if (mem_req_valid_o) o.req_in_done = 1;
      if (outs_differ(o)) o.out_unstable = 1;
      @(negedge clk);
    end
    if (mem_req_valid_o) o.req_in_done = 1;
    if (outs_differ(o) || !lsu_valid_o) o.out_unstable = 1;
    wbu_ready_i = 1;
    @(posedge clk); #1;
    wbu_ready_i = 0;
    o.valid_after = lsu_valid_o;
    o.ready_after = lsu_ready_o;
  endtask

  function automatic txn_t base_txn();
    txn_t t;
    t = '{default: 0};
    t.wd = 1; t.wreg = 5'd7; t.csr = 32'hC5C5_0001; t.wdata = 32'h5566_7788;
    return t;
  endfunction

  task automatic test_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({lsu_valid_o, mem_req_valid_o, wd_o, exc_o} !== 4'b0 || lsu_ready_o !== 1'b1 ||
        wdata_o !== 32'd0 || wreg_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b req=%b wd=%b exc=%b ready=%b wdata=%h, need 0,0,0,0,1,0",
               lsu_valid_o, mem_req_valid_o, wd_o, exc_o, lsu_ready_o, wdata_o);
    end
    rst = 1;
  endtask

  task automatic test_alu();
    txn_t t; obs_t o;
    t = base_txn(); t.wreg = 5'd3; t.alu = 32'h1234; t.wbu_delay = 1;
    run_txn(t, o);
    checks++;
    if (o.timed_out || o.lat != 0) begin
      errors++; $display("FAIL alu_latency: got %0d (timeout=%0d), need 0", o.lat, o.timed_out);
    end
    checks++;
    if (o.res !== 32'h1234 || o.wreg !== 5'd3 || o.wd !== 1'b1 || o.exc !== 1'b0) begin
      errors++; $display("FAIL alu_result: wdata=%h wreg=%0d wd=%b exc=%b, need 1234 3 1 0",
                         o.res, o.wreg, o.wd, o.exc);
    end
    checks++;
    if (o.req_seen || o.csr !== 32'hC5C5_0001) begin
      errors++; $display("FAIL alu_no_bus: req=%0d csr=%h, need 0 c5c50001", o.req_seen, o.csr);
    end
  endtask

  task automatic test_sb();
    txn_t t; obs_t o;
    t = base_txn(); t.st = 2'd1; t.alu = 32'h8000_0003; t.wdata = 32'h0000_00AB;
    run_txn(t, o);
    checks++;
    if (!o.req_seen || o.wen !== 1'b1 || o.addr !== 32'h8000_0000 || o.strb !== 4'b1000 ||
        o.bwdata !== 32'hAB00_0000) begin
      errors++; $display("FAIL sb_request: seen=%0d wen=%b addr=%h strb=%b wdata=%h, need 1 1 80000000 1000 ab000000",
                         o.req_seen, o.wen, o.addr, o.strb, o.bwdata);
    end
    checks++;
    if (o.res !== 32'h8000_0003 || o.wd !== 1'b1 || o.exc !== 1'b0) begin
      errors++; $display("FAIL sb_result: wdata=%h wd=%b exc=%b, need 80000003 1 0", o.res, o.wd, o.exc);
    end
  endtask

  task automatic test_lb_lbu();
    txn_t t; obs_t o;
    t = base_txn(); t.ld = 3'd1; t.alu = 32'h8000_0001; t.rdata = 32'h0000_8000;
    run_txn(t, o);
    checks++;
    if (o.res !== 32'hFFFF_FF80 || o.strb !== 4'd0 || o.wen !== 1'b0) begin
      errors++; $display("FAIL lb_sign: wdata=%h strb=%b wen=%b, need ffffff80 0000 0", o.res, o.strb, o.wen);
    end
    t.ld = 3'd4;
    run_txn(t, o);
    checks++;
    if (o.res !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_zero: wdata=%h, need 00000080", o.res);
    end
  endtask

  task automatic test_stall();
    txn_t t; obs_t o;
    t = base_txn(); t.st = 2'd3; t.alu = 32'h8000_0010; t.wdata = 32'hDEAD_BEEF;
    t.req_delay = 5; t.wbu_delay = 3;
    run_txn(t, o);
    checks++;
    if (o.req_unstable || o.addr !== 32'h8000_0010 || o.strb !== 4'hF || o.bwdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL stall_req_stable: unstable=%0d addr=%h strb=%h wdata=%h, need 0 80000010 f deadbeef",
                         o.req_unstable, o.addr, o.strb, o.bwdata);
    end
    checks++;
    if (o.valid_cycles != 3 || o.out_unstable || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
      errors++; $display("FAIL stall_wbu_hold: cycles=%0d unstable=%0d valid_after=%b ready_after=%b, need 3 0 0 1",
                         o.valid_cycles, o.out_unstable, o.valid_after, o.ready_after);
    end
  endtask

  task automatic test_misaligned();
    txn_t t; obs_t o;
    t = base_txn(); t.ld = 3'd3; t.alu = 32'h8000_0002; t.rdata = 32'h1122_3344;
    run_txn(t, o);
    if (TRAP) begin
      checks++;
      if (o.exc !== 1'b1 || o.cause !== 4'd4 || o.tval !== 32'h8000_0002 || o.wd !== 1'b0 || o.req_seen) begin
        errors++; $display("FAIL lw_misaligned_trap: exc=%b cause=%0d tval=%h wd=%b req=%0d, need 1 4 80000002 0 0",
                           o.exc, o.cause, o.tval, o.wd, o.req_seen);
      end
    end else begin
      checks++;
      if (o.exc !== 1'b0 || o.addr !== 32'h8000_0000 || o.res !== 32'h1122_3344 || !o.req_seen) begin
        errors++; $display("FAIL lw_misaligned_trunc: exc=%b addr=%h wdata=%h req=%0d, need 0 80000000 11223344 1",
                           o.exc, o.addr, o.res, o.req_seen);
      end
    end
  endtask

  task automatic test_timeout();
    txn_t t; obs_t o;
    t = base_txn(); t.ld = 3'd3; t.alu = 32'h8000_0020; t.no_rsp = 1;
    run_txn(t, o);
    checks++;
    if (o.timed_out || o.exc !== 1'b1 || o.cause !== 4'd5 || o.wd !== 1'b0 || o.tval !== 32'h8000_0020) begin
      errors++; $display("FAIL timeout_fault: to=%0d exc=%b cause=%0d wd=%b tval=%h, need 0 1 5 0 80000020",
                         o.timed_out, o.exc, o.cause, o.wd, o.tval);
    end
    checks++;
    if (o.lat < TMO + 1 || o.lat > TMO + 2) begin
      errors++; $display("FAIL timeout_latency: got %0d, need %0d..%0d", o.lat, TMO + 1, TMO + 2);
    end
    // late response arriving in IDLE must not disturb the next instruction
    @(negedge clk); mem_rsp_valid_i = 1; mem_rsp_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk); mem_rsp_valid_i = 0;
    t = base_txn(); t.alu = 32'h0000_0042;
    run_txn(t, o);
    checks++;
    if (o.lat != 0 || o.res !== 32'h42 || o.exc !== 1'b0) begin
      errors++; $display("FAIL late_rsp_ignored: lat=%0d wdata=%h exc=%b, need 0 00000042 0", o.lat, o.res, o.exc);
    end
  endtask

  task automatic test_stray_and_err();
    txn_t t; obs_t o;
    t = base_txn(); t.ld = 3'd3; t.alu = 32'h8000_0030; t.rdata = 32'hCAFE_F00D;
    t.stray = 1; t.req_delay = 2;
    run_txn(t, o);
    checks++;
    if (o.res !== 32'hCAFE_F00D || o.exc !== 1'b0) begin
      errors++; $display("FAIL stray_rsp_ignored: wdata=%h exc=%b, need cafef00d 0", o.res, o.exc);
    end
    t = base_txn(); t.st = 2'd2; t.alu = 32'h8000_0034; t.err = 1;
    run_txn(t, o);
    checks++;
    if (o.exc !== 1'b1 || o.cause !== 4'd7 || o.wd !== 1'b0 || o.tval !== 32'h8000_0034) begin
      errors++; $display("FAIL store_fault: exc=%b cause=%0d wd=%b tval=%h, need 1 7 0 80000034",
                         o.exc, o.cause, o.wd, o.tval);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    exu_valid_i = 1; load_type_i = 3'd3; store_type_i = 0; wd_i = 1; alu_result_i = 32'h8000_0040;
    @(posedge clk); #1;
    exu_valid_i = 0; load_type_i = 0;
    mem_req_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_req_valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_req_pending: req_valid=%b, need 1", mem_req_valid_o);
    end
    rst = 0;
    #1;
    checks++;
    if (mem_req_valid_o !== 1'b0 || lsu_valid_o !== 1'b0 || lsu_ready_o !== 1'b1 || wd_o !== 1'b0) begin
      errors++; $display("FAIL async_reset_req: req=%b valid=%b ready=%b wd=%b, need 0 0 1 0",
                         mem_req_valid_o, lsu_valid_o, lsu_ready_o, wd_o);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_back_to_back();
    txn_t t; obs_t o; exp_t e;
    int op;
    for (int n = 0; n < 40; n++) begin
      t = '{default: 0};
      op = $urandom_range(0, 8);
      t.ld = (op >= 1 && op <= 5) ? 3'(op) : 3'd0;
      t.st = (op >= 6) ? 2'(op - 5) : 2'd0;
      t.wd = 1'($urandom); t.wreg = 5'($urandom);
      t.alu = 32'h8000_0000 | ($urandom & 32'hFF);
      t.wdata = $urandom; t.csr = $urandom; t.rdata = $urandom;
      t.req_delay = $urandom_range(0, 3); t.rsp_delay = $urandom_range(0, 3);
      t.wbu_delay = $urandom_range(0, 3);
      t.err = ($urandom_range(0, 9) == 0); t.no_rsp = ($urandom_range(0, 14) == 0);
      e = model(t);
      run_txn(t, o);
      checks++;
      if (o.timed_out || o.ready_before !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_handshake: stuck=%0d ready=%b", n, o.timed_out, o.ready_before);
        continue;
      end
      checks++;
      if (o.req_seen != e.mem || o.req_in_done) begin
        errors++; $display("FAIL rnd%0d_req_presence: got %0d (in_done %0d), need %0d", n, o.req_seen, o.req_in_done, e.mem);
      end
      if (e.mem) begin
        checks++;
        if (o.wen !== e.wen || o.addr !== e.addr || o.strb !== e.strb || o.bwdata !== e.bwdata || o.req_unstable) begin
          errors++; $display("FAIL rnd%0d_request: wen=%b addr=%h strb=%b wdata=%h unst=%0d, need %b %h %b %h 0",
                             n, o.wen, o.addr, o.strb, o.bwdata, o.req_unstable, e.wen, e.addr, e.strb, e.bwdata);
        end
      end
      checks++;
      if (o.exc !== e.exc || o.wd !== e.wd || o.wreg !== t.wreg || o.csr !== t.csr) begin
        errors++; $display("FAIL rnd%0d_ctrl: exc=%b wd=%b wreg=%0d csr=%h, need %b %b %0d %h",
                           n, o.exc, o.wd, o.wreg, o.csr, e.exc, e.wd, t.wreg, t.csr);
      end
      checks++;
      if (e.exc ? (o.cause !== e.cause || o.tval !== t.alu) : (o.res !== e.res)) begin
        errors++; $display("FAIL rnd%0d_data: wdata=%h cause=%0d tval=%h, need wdata=%h or cause=%0d tval=%h",
                           n, o.res, o.cause, o.tval, e.res, e.cause, t.alu);
      end
      checks++;
      if (o.valid_cycles != t.wbu_delay || o.out_unstable || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_wbu: cycles=%0d unst=%0d valid_after=%b ready_after=%b, need %0d 0 0 1",
                           n, o.valid_cycles, o.out_unstable, o.valid_after, o.ready_after, t.wbu_delay);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_sb();
    test_lb_lbu();
    test_stall();
    test_misaligned();
    test_timeout();
    test_stray_and_err();
    test_reset_mid_req();
    test_alu();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
